// File: rtl/sprite_table_scheduler_if.sv
// Sprite generator snapshot inputs and sprite RAM write port, with sequencing status.
// The scheduler takes the master modport; the generator/RAM side takes the slave modport.
interface sprite_table_scheduler_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                      frame_start;
    logic [N_SRC-1:0]          src_valid;
    logic [N_SRC*DATA_W-1:0]   src_dina;
    logic [N_SRC*ADDR_W-1:0]   src_addr;
    logic                      ram_grant;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_din;
    logic                      busy;
    logic                      done;
    logic                      conflict;
    logic                      missed;

    modport master (
        input  frame_start, src_valid, src_dina, src_addr, ram_grant,
        output ram_we, ram_addr, ram_din, busy, done, conflict, missed
    );

    modport slave (
        output frame_start, src_valid, src_dina, src_addr, ram_grant,
        input  ram_we, ram_addr, ram_din, busy, done, conflict, missed
    );
endinterface

// File: rtl/sprite_table_scheduler.sv
// Snapshots all sprite generators on frame_start and serialises their valid
// descriptors into the single sprite RAM write port, in index order, as grant allows.
//
//   state | meaning
//   IDLE  | waiting for frame_start; RAM outputs held at 0
//   SCAN  | walking shadow entry idx: skip, write, or stall on grant
//   DONE  | one-cycle done pulse, then back to IDLE
module sprite_table_scheduler #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    sprite_table_scheduler_if.master  bus
);
    localparam int IDX_W = $clog2(N_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [N_SRC-1:0]   sh_valid;
    logic [DATA_W-1:0]  sh_dina [N_SRC];
    logic [ADDR_W-1:0]  sh_addr [N_SRC];
    logic               busy_q;
    logic               done_q;
    logic               conflict_q;
    logic               missed_q;
    logic               dup;
    logic               in_scan;

    // Duplicate slot check is over the live inputs, which become the snapshot at capture.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int j = i + 1; j < N_SRC; j++) begin
                if (bus.src_valid[i] && bus.src_valid[j] &&
                    bus.src_addr[i*ADDR_W +: ADDR_W] == bus.src_addr[j*ADDR_W +: ADDR_W])
                    dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            sh_valid   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                sh_dina[i] <= '0;
                sh_addr[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.frame_start && state != IDLE)
                missed_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        sh_valid <= bus.src_valid;
                        for (int i = 0; i < N_SRC; i++) begin
                            sh_dina[i] <= bus.src_dina[i*DATA_W +: DATA_W];
                            sh_addr[i] <= bus.src_addr[i*ADDR_W +: ADDR_W];
                        end
                        idx    <= '0;
                        state  <= SCAN;
                        busy_q <= 1'b1;
                        if (dup)
                            conflict_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!sh_valid[idx] || bus.ram_grant) begin
                        if (idx == LAST_IDX) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobe and data follow the current shadow entry in the same cycle.
    assign in_scan      = (state == SCAN);
    assign bus.ram_we   = in_scan && sh_valid[idx] && bus.ram_grant;
    assign bus.ram_addr = in_scan ? sh_addr[idx] : '0;
    assign bus.ram_din  = in_scan ? sh_dina[idx] : '0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.conflict = conflict_q;
    assign bus.missed   = missed_q;
endmodule

// File: tb/tb_sprite_table_scheduler.sv
// Directed bench for sprite_table_scheduler: per-frame write log compared against
// hand-computed cycle/address/data expectations.
module tb_sprite_table_scheduler;
    localparam int N_SRC  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    int               wr_n;
    int               wr_cyc  [8];
    logic [ADDR_W-1:0] wr_addr [8];
    logic [DATA_W-1:0] wr_data [8];
    int               done_n;
    int               done_cyc;
    logic             busy_at [21];

    sprite_table_scheduler_if #(.N_SRC(N_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sprite_table_scheduler #(.N_SRC(N_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] desc(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic set_src(input logic [N_SRC-1:0] valid, input int a0, input int a1,
                           input int a2, input int a3);
        int a [4];
        a = '{a0, a1, a2, a3};
        bus.src_valid = valid;
        for (int i = 0; i < N_SRC; i++) begin
            bus.src_dina[i*DATA_W +: DATA_W] = desc(i);
            bus.src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a[i]);
        end
    endtask

    // Runs one frame: pulse frame_start at edge 0, then log cycles 1..20.
    task automatic run_frame(input logic [20:0] grant_low, input int fs2_cycle, input int chg_cycle);
        wr_n = 0; done_n = 0; done_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            wr_cyc[i] = 0; wr_addr[i] = '0; wr_data[i] = '0;
        end
        @(negedge clk);
        bus.ram_grant   = 1'b1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.ram_grant   = ~grant_low[k];
            bus.frame_start = (k == fs2_cycle);
            if (k == chg_cycle) begin
                bus.src_valid = '0;
                bus.src_dina  = '1;
                bus.src_addr  = '1;
            end
            @(negedge clk);
            busy_at[k] = bus.busy;
            if (bus.ram_we) begin
                if (wr_n < 8) begin
                    wr_cyc[wr_n]  = k;
                    wr_addr[wr_n] = bus.ram_addr;
                    wr_data[wr_n] = bus.ram_din;
                end
                wr_n++;
            end
            if (bus.done) begin
                done_n++;
                done_cyc = k;
            end
            @(posedge clk); #1;
        end
        bus.frame_start = 1'b0;
        bus.ram_grant   = 1'b1;
    endtask

    task automatic expect_write(input string tag, input int n, input int cyc,
                                input int addr, input int src);
        check({tag, "_cyc"},  64'(wr_cyc[n]),  64'(cyc));
        check({tag, "_addr"}, 64'(wr_addr[n]), 64'(addr));
        check({tag, "_data"}, 64'(wr_data[n]), 64'(desc(src)));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.ram_grant   = 1'b1;
        bus.src_valid   = '0;
        bus.src_dina    = '0;
        bus.src_addr    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",       64'(bus.ram_we),   64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_conflict", 64'(bus.conflict), 64'd0);
        check("rst_missed",   64'(bus.missed),   64'd0);
        check("rst_addr",     64'(bus.ram_addr), 64'd0);
        check("rst_din",      64'(bus.ram_din),  64'd0);
        reset = 1'b0;

        // all valid, full grant
        set_src(4'b1111, 0, 1, 2, 3);
        run_frame(21'd0, 0, 0);
        check("t1_nwr", 64'(wr_n), 64'd4);
        for (int i = 0; i < 4; i++) expect_write("t1_wr", i, i + 1, i, i);
        check("t1_done_cyc", 64'(done_cyc), 64'd5);
        check("t1_done_n",   64'(done_n),   64'd1);
        check("t1_busy1",    64'(busy_at[1]), 64'd1);
        check("t1_busy5",    64'(busy_at[5]), 64'd1);
        check("t1_busy6",    64'(busy_at[6]), 64'd0);
        check("t1_conflict", 64'(bus.conflict), 64'd0);

        // sparse valid: skips take a cycle each
        set_src(4'b0101, 0, 1, 2, 3);
        run_frame(21'd0, 0, 0);
        check("t2_nwr", 64'(wr_n), 64'd2);
        expect_write("t2_wr0", 0, 1, 0, 0);
        expect_write("t2_wr1", 1, 3, 2, 2);
        check("t2_done_cyc", 64'(done_cyc), 64'd5);

        // grant low in cycles 2..4, inputs scrambled at cycle 3
        set_src(4'b1111, 4, 5, 6, 7);
        run_frame(21'h1C, 0, 3);
        check("t3_nwr", 64'(wr_n), 64'd4);
        expect_write("t3_wr0", 0, 1, 4, 0);
        expect_write("t3_wr1", 1, 5, 5, 1);
        expect_write("t3_wr2", 2, 6, 6, 2);
        expect_write("t3_wr3", 3, 7, 7, 3);
        check("t3_done_cyc", 64'(done_cyc), 64'd8);
        check("t3_conflict", 64'(bus.conflict), 64'd0);
        check("t3_missed",   64'(bus.missed),   64'd0);

        // src1 and src3 share slot 2
        set_src(4'b1111, 0, 2, 1, 2);
        run_frame(21'd0, 0, 0);
        check("t4_nwr", 64'(wr_n), 64'd4);
        expect_write("t4_wr1", 1, 2, 2, 1);
        expect_write("t4_wr3", 3, 4, 2, 3);
        check("t4_conflict", 64'(bus.conflict), 64'd1);
        set_src(4'b1111, 0, 1, 2, 3);
        run_frame(21'd0, 0, 0);
        check("t4_conflict_sticky", 64'(bus.conflict), 64'd1);

        // second frame_start while scanning
        run_frame(21'd0, 2, 0);
        check("t5_nwr",    64'(wr_n),   64'd4);
        check("t5_done_n", 64'(done_n), 64'd1);
        check("t5_done_cyc", 64'(done_cyc), 64'd5);
        check("t5_missed", 64'(bus.missed), 64'd1);

        // async reset between edges mid-scan
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        @(posedge clk); #2;
        check("t6_we_before", 64'(bus.ram_we), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_we",       64'(bus.ram_we),   64'd0);
        check("t6_busy",     64'(bus.busy),     64'd0);
        check("t6_done",     64'(bus.done),     64'd0);
        check("t6_conflict", 64'(bus.conflict), 64'd0);
        check("t6_missed",   64'(bus.missed),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(21'd0, 0, 0);
        check("t6_nwr", 64'(wr_n), 64'd4);
        for (int i = 0; i < 4; i++) expect_write("t6_wr", i, i + 1, i, i);
        check("t6_done_cyc", 64'(done_cyc), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
